calc_sequencer: RTL and testbench

Operation sequencer for the basic calculator datapath. It takes debounced enter/clear pulses and switch operands from input setup, collects operand A, operand B and operator, and launches one operation on the shared iterative arithmetic unit through a start/busy/done handshake. It captures the result or error and drives the display mux select and status LEDs. It supports result chaining and an operation timeout, and replaces the ad-hoc state controller / enable-pulse pairing at the calculator top level.

---
 rtl/calc_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Operation sequencer for the calculator: collects A, B and operator, launches one
// operation on the shared arithmetic unit, and holds the result/error for display.
module calc_sequencer #(
    parameter int WIDTH          = 40,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_enter,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_value_sign,
    input  logic [1:0]       i_op,
    output logic             o_start,
    output logic [1:0]       o_op,
    output logic [WIDTH-1:0] o_a,
    output logic             o_a_sign,
    output logic [WIDTH-1:0] o_b,
    output logic             o_b_sign,
    input  logic             i_busy,
    input  logic             i_done,
    input  logic [WIDTH-1:0] i_result,
    input  logic             i_result_sign,
    input  logic             i_err,
    output logic [WIDTH-1:0] o_result,
    output logic             o_result_sign,
    output logic [1:0]       o_display_sel,
    output logic [3:0]       o_state_led,
    output logic             o_err,
    output logic             o_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_SHOW    = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             a_sign_q, a_sign_d;
    logic             b_sign_q, b_sign_d;
    logic             result_sign_q, result_sign_d;
    logic [1:0]       op_q, op_d;
    logic             start_q, start_d;
    logic             err_q, err_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       led_q, led_d;

    logic div_by_zero;
    logic timeout_hit;

    assign div_by_zero = (i_op == 2'b11) && (i_value == '0);
    assign timeout_hit = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= ST_ENTER_A;
            a_q           <= '0;
            a_sign_q      <= 1'b0;
            b_q           <= '0;
            b_sign_q      <= 1'b0;
            result_q      <= '0;
            result_sign_q <= 1'b0;
            op_q          <= 2'b00;
            start_q       <= 1'b0;
            err_q         <= 1'b0;
            timeout_q     <= 1'b0;
            cnt_q         <= '0;
            sel_q         <= 2'b00;
            led_q         <= 4'b0001;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            a_sign_q      <= a_sign_d;
            b_q           <= b_d;
            b_sign_q      <= b_sign_d;
            result_q      <= result_d;
            result_sign_q <= result_sign_d;
            op_q          <= op_d;
            start_q       <= start_d;
            err_q         <= err_d;
            timeout_q     <= timeout_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            led_q         <= led_d;
        end
    end

    // Next-state logic; clear overrides every state
    always_comb begin
        state_d = state_q;
        if (i_clear) begin
            state_d = ST_ENTER_A;
        end else begin
            case (state_q)
                ST_ENTER_A: if (i_enter) state_d = ST_ENTER_B;
                ST_ENTER_B: if (i_enter) state_d = div_by_zero ? ST_ERROR : ST_ISSUE;
                ST_ISSUE:   if (!i_busy) state_d = ST_WAIT;
                ST_WAIT: begin
                    if (i_done)           state_d = i_err ? ST_ERROR : ST_SHOW;
                    else if (timeout_hit) state_d = ST_ERROR;
                end
                ST_SHOW:    if (i_enter) state_d = ST_ENTER_B;
                ST_ERROR:   state_d = ST_ERROR;
                default:    state_d = ST_ENTER_A;
            endcase
        end
    end

    // Registered outputs and datapath captures for the coming cycle
    always_comb begin
        a_d           = a_q;
        a_sign_d      = a_sign_q;
        b_d           = b_q;
        b_sign_d      = b_sign_q;
        result_d      = result_q;
        result_sign_d = result_sign_q;
        op_d          = op_q;
        start_d       = 1'b0;
        err_d         = err_q;
        timeout_d     = timeout_q;
        cnt_d         = cnt_q;
        sel_d         = 2'b00;
        led_d         = 4'b0001;

        if (i_clear) begin
            a_d           = '0;
            a_sign_d      = 1'b0;
            b_d           = '0;
            b_sign_d      = 1'b0;
            result_d      = '0;
            result_sign_d = 1'b0;
            op_d          = 2'b00;
            err_d         = 1'b0;
            timeout_d     = 1'b0;
            cnt_d         = '0;
        end else begin
            case (state_q)
                ST_ENTER_A: begin
                    if (i_enter) begin
                        a_d      = i_value;
                        a_sign_d = i_value_sign;
                    end
                end
                ST_ENTER_B: begin
                    if (i_enter) begin
                        b_d      = i_value;
                        b_sign_d = i_value_sign;
                        op_d     = i_op;
                        if (div_by_zero) err_d = 1'b1;
                    end
                end
                ST_ISSUE: begin
                    cnt_d = '0;
                    if (!i_busy) start_d = 1'b1;
                end
                ST_WAIT: begin
                    if (i_done) begin
                        result_d      = i_result;
                        result_sign_d = i_result_sign;
                        err_d         = i_err;
                    end else if (timeout_hit) begin
                        err_d     = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    // Chaining: the last result becomes operand A of the next operation
                    if (i_enter) begin
                        a_d      = result_q;
                        a_sign_d = result_sign_q;
                    end
                end
                default: ;
            endcase
        end

        case (state_d)
            ST_ENTER_A: begin sel_d = 2'b00; led_d = 4'b0001; end
            ST_ENTER_B: begin sel_d = 2'b01; led_d = 4'b0010; end
            ST_ISSUE:   begin sel_d = 2'b01; led_d = 4'b0100; end
            ST_WAIT:    begin sel_d = 2'b01; led_d = 4'b0100; end
            ST_SHOW:    begin sel_d = 2'b11; led_d = 4'b1000; end
            ST_ERROR:   begin sel_d = 2'b10; led_d = 4'b1111; end
            default:    begin sel_d = 2'b00; led_d = 4'b0001; end
        endcase
    end

    assign o_start       = start_q;
    assign o_op          = op_q;
    assign o_a           = a_q;
    assign o_a_sign      = a_sign_q;
    assign o_b           = b_q;
    assign o_b_sign      = b_sign_q;
    assign o_result      = result_q;
    assign o_result_sign = result_sign_q;
    assign o_display_sel = sel_q;
    assign o_state_led   = led_q;
    assign o_err         = err_q;
    assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: a vector table, directed multi-cycle sequences and
// randomized traffic checked against a phase-level reference model.
module tb_calc_sequencer;

    localparam int W  = 40;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_enter, i_clear, i_value_sign, i_busy, i_done, i_result_sign, i_err;
    logic [W-1:0] i_value, i_result;
    logic [1:0]   i_op;
    logic         o_start, o_a_sign, o_b_sign, o_result_sign, o_err, o_timeout;
    logic [1:0]   o_op, o_display_sel;
    logic [W-1:0] o_a, o_b, o_result;
    logic [3:0]   o_state_led;

    int n_total = 0;
    int n_pass  = 0;

    calc_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_enter(i_enter), .i_clear(i_clear),
        .i_value(i_value), .i_value_sign(i_value_sign), .i_op(i_op),
        .o_start(o_start), .o_op(o_op),
        .o_a(o_a), .o_a_sign(o_a_sign), .o_b(o_b), .o_b_sign(o_b_sign),
        .i_busy(i_busy), .i_done(i_done),
        .i_result(i_result), .i_result_sign(i_result_sign), .i_err(i_err),
        .o_result(o_result), .o_result_sign(o_result_sign),
        .o_display_sel(o_display_sel), .o_state_led(o_state_led),
        .o_err(o_err), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock: drive inputs, let the edge sample them, settle just after.
    task automatic cyc(input logic clr, input logic ent, input logic [W-1:0] val, input logic vs,
                       input logic [1:0] op, input logic busy, input logic done,
                       input logic [W-1:0] res, input logic rs, input logic rerr);
        i_clear = clr; i_enter = ent; i_value = val; i_value_sign = vs; i_op = op;
        i_busy = busy; i_done = done; i_result = res; i_result_sign = rs; i_err = rerr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, '0, 0, 2'b00, 0, 0, '0, 0, 0);
    endtask

    task automatic enter(input logic [W-1:0] val, input logic [1:0] op);
        cyc(0, 1, val, 0, op, 0, 0, '0, 0, 0);
    endtask

    task automatic clear();
        cyc(1, 0, '0, 0, 2'b00, 0, 0, '0, 0, 0);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic clr; logic ent; logic [W-1:0] val; logic [1:0] op;
        logic busy; logic done; logic [W-1:0] res; logic rerr;
        logic [3:0] e_led; logic [1:0] e_sel; logic e_start; logic [1:0] e_op;
        logic [W-1:0] e_a; logic [W-1:0] e_b; logic [W-1:0] e_res; logic e_err;
    } vec_t;

    function automatic vec_t mk(input logic clr, input logic ent, input int val, input logic [1:0] op,
                                input logic busy, input logic done, input int res, input logic rerr,
                                input logic [3:0] e_led, input logic [1:0] e_sel, input logic e_start,
                                input logic [1:0] e_op, input int e_a, input int e_b,
                                input int e_res, input logic e_err);
        vec_t v;
        v.clr = clr; v.ent = ent; v.val = W'(val); v.op = op;
        v.busy = busy; v.done = done; v.res = W'(res); v.rerr = rerr;
        v.e_led = e_led; v.e_sel = e_sel; v.e_start = e_start; v.e_op = e_op;
        v.e_a = W'(e_a); v.e_b = W'(e_b); v.e_res = W'(e_res); v.e_err = e_err;
        return v;
    endfunction

    vec_t vecs[21];

    // ---------------- reference model ----------------
    string        phase;
    logic [W-1:0] m_a, m_b, m_res;
    logic         m_as, m_bs, m_rs, m_err, m_to, m_start;
    logic [1:0]   m_op;
    int           m_waited;

    task automatic model_reset();
        phase = "A";
        m_a = '0; m_b = '0; m_res = '0; m_as = 0; m_bs = 0; m_rs = 0;
        m_op = 2'b00; m_err = 0; m_to = 0; m_start = 0; m_waited = 0;
    endtask

    task automatic model_step(input logic clr, input logic ent, input logic [W-1:0] val, input logic vs,
                              input logic [1:0] op, input logic busy, input logic done,
                              input logic [W-1:0] res, input logic rs, input logic rerr);
        m_start = 0;
        if (clr) begin
            model_reset();
        end else if (phase == "A") begin
            if (ent) begin m_a = val; m_as = vs; phase = "B"; end
        end else if (phase == "B") begin
            if (ent) begin
                m_b = val; m_bs = vs; m_op = op;
                if (op == 2'b11 && val == 0) begin m_err = 1; phase = "ERR"; end
                else phase = "ISSUE";
            end
        end else if (phase == "ISSUE") begin
            if (!busy) begin phase = "WAIT"; m_start = 1; m_waited = 0; end
        end else if (phase == "WAIT") begin
            m_waited++;
            if (done) begin
                m_res = res; m_rs = rs; m_err = rerr;
                phase = rerr ? "ERR" : "SHOW";
            end else if (m_waited >= TO) begin
                m_err = 1; m_to = 1; phase = "ERR";
            end
        end else if (phase == "SHOW") begin
            if (ent) begin m_a = m_res; m_as = m_rs; phase = "B"; end
        end
    endtask

    function automatic logic [3:0] exp_led();
        if (phase == "A") return 4'b0001;
        if (phase == "B") return 4'b0010;
        if (phase == "SHOW") return 4'b1000;
        if (phase == "ERR") return 4'b1111;
        return 4'b0100;
    endfunction

    function automatic logic [1:0] exp_sel();
        if (phase == "A") return 2'b00;
        if (phase == "SHOW") return 2'b11;
        if (phase == "ERR") return 2'b10;
        return 2'b01;
    endfunction

    task automatic check_model(input int n);
        chk($sformatf("rnd%0d_led", n), 64'(o_state_led), 64'(exp_led()));
        chk($sformatf("rnd%0d_sel", n), 64'(o_display_sel), 64'(exp_sel()));
        chk($sformatf("rnd%0d_start", n), 64'(o_start), 64'(m_start));
        chk($sformatf("rnd%0d_op", n), 64'(o_op), 64'(m_op));
        chk($sformatf("rnd%0d_a", n), 64'({o_a_sign, o_a}), 64'({m_as, m_a}));
        chk($sformatf("rnd%0d_b", n), 64'({o_b_sign, o_b}), 64'({m_bs, m_b}));
        chk($sformatf("rnd%0d_res", n), 64'({o_result_sign, o_result}), 64'({m_rs, m_res}));
        chk($sformatf("rnd%0d_err", n), 64'(o_err), 64'(m_err));
        chk($sformatf("rnd%0d_to", n), 64'(o_timeout), 64'(m_to));
    endtask

    initial begin
        vec_t v;
        logic [63:0] r64;
        logic ent, clr, vs, busy, done, rs, rerr;
        logic [W-1:0] val, res;
        logic [1:0] op;

        //             clr ent val op busy done res err | led     sel  st op  a  b  res err
        vecs[0]  = mk(0, 1, 25, 0, 0, 0, 0,  0, 4'b0010, 2'b01, 0, 0, 25, 0,  0,  0);
        vecs[1]  = mk(0, 1, 17, 0, 0, 0, 0,  0, 4'b0100, 2'b01, 0, 0, 25, 17, 0,  0);
        vecs[2]  = mk(0, 0, 0,  0, 0, 0, 0,  0, 4'b0100, 2'b01, 1, 0, 25, 17, 0,  0);
        vecs[3]  = mk(0, 0, 0,  0, 0, 0, 0,  0, 4'b0100, 2'b01, 0, 0, 25, 17, 0,  0);
        vecs[4]  = mk(0, 0, 0,  0, 0, 0, 0,  0, 4'b0100, 2'b01, 0, 0, 25, 17, 0,  0);
        vecs[5]  = mk(0, 0, 0,  0, 0, 0, 0,  0, 4'b0100, 2'b01, 0, 0, 25, 17, 0,  0);
        vecs[6]  = mk(0, 0, 0,  0, 0, 0, 0,  0, 4'b0100, 2'b01, 0, 0, 25, 17, 0,  0);
        vecs[7]  = mk(0, 0, 0,  0, 0, 1, 42, 0, 4'b1000, 2'b11, 0, 0, 25, 17, 42, 0);
        vecs[8]  = mk(0, 0, 0,  0, 0, 0, 0,  0, 4'b1000, 2'b11, 0, 0, 25, 17, 42, 0);
        vecs[9]  = mk(0, 1, 99, 1, 0, 0, 0,  0, 4'b0010, 2'b01, 0, 0, 42, 17, 42, 0);
        vecs[10] = mk(0, 1, 2,  2, 0, 0, 0,  0, 4'b0100, 2'b01, 0, 2, 42, 2,  42, 0);
        vecs[11] = mk(0, 0, 0,  0, 1, 0, 0,  0, 4'b0100, 2'b01, 0, 2, 42, 2,  42, 0);
        vecs[12] = mk(0, 0, 0,  0, 0, 0, 0,  0, 4'b0100, 2'b01, 1, 2, 42, 2,  42, 0);
        vecs[13] = mk(0, 0, 0,  0, 0, 1, 84, 0, 4'b1000, 2'b11, 0, 2, 42, 2,  84, 0);
        vecs[14] = mk(0, 0, 0,  0, 0, 1, 7,  0, 4'b1000, 2'b11, 0, 2, 42, 2,  84, 0);
        vecs[15] = mk(1, 0, 0,  0, 0, 0, 0,  0, 4'b0001, 2'b00, 0, 0, 0,  0,  0,  0);
        vecs[16] = mk(0, 1, 9,  0, 0, 0, 0,  0, 4'b0010, 2'b01, 0, 0, 9,  0,  0,  0);
        vecs[17] = mk(0, 1, 0,  3, 0, 0, 0,  0, 4'b1111, 2'b10, 0, 3, 9,  0,  0,  1);
        vecs[18] = mk(0, 1, 5,  0, 0, 0, 0,  0, 4'b1111, 2'b10, 0, 3, 9,  0,  0,  1);
        vecs[19] = mk(0, 0, 0,  0, 0, 1, 5,  0, 4'b1111, 2'b10, 0, 3, 9,  0,  0,  1);
        vecs[20] = mk(1, 0, 0,  0, 0, 0, 0,  0, 4'b0001, 2'b00, 0, 0, 0,  0,  0,  0);

        rst_n = 1'b0;
        i_clear = 0; i_enter = 0; i_value = '0; i_value_sign = 0; i_op = 2'b00;
        i_busy = 0; i_done = 0; i_result = '0; i_result_sign = 0; i_err = 0;
        @(posedge clk); #1;
        chk("reset_led", 64'(o_state_led), 64'(4'b0001));
        chk("reset_sel", 64'(o_display_sel), 64'(2'b00));
        chk("reset_flags", 64'({o_start, o_err, o_timeout}), 64'(3'b000));
        rst_n = 1'b1;
        idle();

        // Table: add, chaining multiply, stale done, divide-by-zero error, clear
        for (int i = 0; i < 21; i++) begin
            v = vecs[i];
            cyc(v.clr, v.ent, v.val, 0, v.op, v.busy, v.done, v.res, 0, v.rerr);
            chk($sformatf("tbl%0d_led", i), 64'(o_state_led), 64'(v.e_led));
            chk($sformatf("tbl%0d_sel", i), 64'(o_display_sel), 64'(v.e_sel));
            chk($sformatf("tbl%0d_start", i), 64'(o_start), 64'(v.e_start));
            chk($sformatf("tbl%0d_op", i), 64'(o_op), 64'(v.e_op));
            chk($sformatf("tbl%0d_a", i), 64'(o_a), 64'(v.e_a));
            chk($sformatf("tbl%0d_b", i), 64'(o_b), 64'(v.e_b));
            chk($sformatf("tbl%0d_res", i), 64'(o_result), 64'(v.e_res));
            chk($sformatf("tbl%0d_err", i), 64'(o_err), 64'(v.e_err));
        end

        // Timeout: no done for the whole WAIT window
        enter(3, 2'b00); enter(4, 2'b00); idle();
        for (int k = 1; k < TO; k++) begin
            idle();
            chk($sformatf("to_wait%0d_led", k), 64'(o_state_led), 64'(4'b0100));
        end
        idle();
        chk("to_led", 64'(o_state_led), 64'(4'b1111));
        chk("to_flags", 64'({o_err, o_timeout}), 64'(2'b11));
        clear();
        chk("to_clear_flags", 64'({o_err, o_timeout}), 64'(2'b00));

        // Done arriving on the last WAIT cycle beats the timeout
        enter(3, 2'b00); enter(4, 2'b00); idle();
        for (int k = 1; k < TO; k++) idle();
        cyc(0, 0, '0, 0, 2'b00, 0, 1, W'(123), 1, 0);
        chk("late_done_led", 64'(o_state_led), 64'(4'b1000));
        chk("late_done_to", 64'({o_err, o_timeout}), 64'(2'b00));
        chk("late_done_res", 64'({o_result_sign, o_result}), 64'({1'b1, W'(123)}));
        clear();

        // Busy held in ISSUE: launch only after busy drops
        enter(6, 2'b01); enter(1, 2'b01);
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, '0, 0, 2'b00, 1, 0, '0, 0, 0);
            chk($sformatf("busy%0d_start", k), 64'({o_start, o_state_led}), 64'({1'b0, 4'b0100}));
        end
        cyc(0, 0, '0, 0, 2'b00, 0, 0, '0, 0, 0);
        chk("busy_drop_start", 64'(o_start), 64'(1));
        idle();
        chk("busy_single_pulse", 64'(o_start), 64'(0));
        clear();

        // Clear and enter together in ENTER_B
        enter(7, 2'b00);
        cyc(1, 1, W'(55), 0, 2'b00, 0, 0, '0, 0, 0);
        chk("clr_ent_led", 64'(o_state_led), 64'(4'b0001));
        chk("clr_ent_b", 64'(o_b), 64'(0));
        chk("clr_ent_a", 64'(o_a), 64'(0));

        // Asynchronous reset mid-WAIT, then a stale done
        enter(8, 2'b00); enter(2, 2'b00); idle();
        chk("pre_rst_start", 64'(o_start), 64'(1));
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_start", 64'(o_start), 64'(0));
        chk("async_rst_led", 64'(o_state_led), 64'(4'b0001));
        chk("async_rst_ab", 64'({o_a, o_b}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(0, 0, '0, 0, 2'b00, 0, 1, W'(77), 0, 0);
        chk("stale_done_led", 64'(o_state_led), 64'(4'b0001));
        chk("stale_done_res", 64'(o_result), 64'(0));

        // Randomized traffic against the reference model
        clear();
        model_reset();
        for (int n = 0; n < 2500; n++) begin
            clr  = ($urandom_range(0, 39) == 0);
            ent  = ($urandom_range(0, 9) < 3);
            r64  = {$urandom(), $urandom()};
            val  = ($urandom_range(0, 4) == 0) ? '0 : r64[W-1:0];
            vs   = 1'($urandom_range(0, 1));
            op   = 2'($urandom_range(0, 3));
            busy = ($urandom_range(0, 9) < 3);
            done = ($urandom_range(0, 99) < 12);
            r64  = {$urandom(), $urandom()};
            res  = r64[W-1:0];
            rs   = 1'($urandom_range(0, 1));
            rerr = ($urandom_range(0, 3) == 0);
            cyc(clr, ent, val, vs, op, busy, done, res, rs, rerr);
            model_step(clr, ent, val, vs, op, busy, done, res, rs, rerr);
            check_model(n);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
